// File: rtl/cfg_tile_loader.sv
// cfg_tile_loader
//   Per-tile configuration receiver for a daisy-chained config fabric.
//   A serial stream is shifted into a shadow frame of {data, CRC-8}. A set pulse
//   starts a bit-serial CRC check over the data field. The data is committed to
//   the live config only when the computed CRC matches the stored one and no
//   shift was dropped while the check was running. The shift and set signals
//   are forwarded so that the next tile in the chain sees the same stream.
//
// Ports
//   clk        in   fabric config clock
//   rst_n      in   asynchronous active-low reset
//   shift_in   in   serial config bit from upstream
//   shift_en   in   shift strobe, one bit per cycle
//   set_in     in   single-cycle commit pulse
//   shift_out  out  serial bit to next tile (MSB of the shadow frame)
//   set_out    out  set_in delayed by one cycle, to next tile
//   cfg_out    out  live config to the tile fabric
//   cfg_valid  out  high once any good frame has committed
//   cfg_err    out  result of the last check, 1 = rejected
//   busy       out  high while checking or committing
module cfg_tile_loader #(
  parameter int                   CFG_WIDTH = 64,
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 8'h07
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_in,
  input  logic                 shift_en,
  input  logic                 set_in,
  output logic                 shift_out,
  output logic                 set_out,
  output logic [CFG_WIDTH-1:0] cfg_out,
  output logic                 cfg_valid,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int FRAME_W = CFG_WIDTH + CRC_WIDTH;
  localparam int IDX_W   = $clog2(CFG_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [FRAME_W-1:0]   sr;
  logic [CRC_WIDTH-1:0] crc;
  logic [IDX_W-1:0]     idx;
  logic                 ovr;
  logic [CFG_WIDTH-1:0] data;
  logic                 crc_ok;

  // One MSB-first CRC step: shift the register left and fold in the
  // polynomial whenever the outgoing bit differs from the incoming data bit.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c,
                                                    input logic                 b);
    logic fb;
    fb = c[CRC_WIDTH-1] ^ b;
    return {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_WIDTH{1'b0}});
  endfunction

  assign data      = sr[FRAME_W-1:CRC_WIDTH];
  assign shift_out = sr[FRAME_W-1];
  // A dropped shift means the frame the upstream believes it sent is not the
  // one held here, so it poisons the check even if the CRC happens to match.
  assign crc_ok    = (crc == sr[CRC_WIDTH-1:0]) && !ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (set_in) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (idx == '0) state_nxt = COMMIT;
      end
      COMMIT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      crc       <= '0;
      idx       <= '0;
      ovr       <= 1'b0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
      set_out   <= 1'b0;
    end else begin
      // Forwarded unconditionally so the next tile starts one cycle later.
      set_out <= set_in;

      // The shadow frame is frozen while a check is in flight.
      if (shift_en) begin
        if (state == IDLE) begin
          sr <= {sr[FRAME_W-2:0], shift_in};
        end else begin
          ovr <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (set_in) begin
            crc <= '0;
            idx <= IDX_W'(CFG_WIDTH - 1);
          end
        end
        CHECK: begin
          crc <= crc_step(crc, data[idx]);
          if (idx != '0) idx <= idx - 1'b1;
        end
        COMMIT: begin
          if (crc_ok) begin
            cfg_out   <= data;
            cfg_valid <= 1'b1;
            cfg_err   <= 1'b0;
          end else begin
            cfg_err   <= 1'b1;
          end
          // Cleared after the verdict; overrides a drop in this same cycle.
          ovr <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_tile_loader.sv
// Bench for cfg_tile_loader: two chained 16-bit tiles (A feeds B) driven by
// directed frames, checked every cycle against a transaction-level model plus
// literal expectations for the documented scenarios.
module tb_cfg_tile_loader;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          shift_in;
  logic          shift_en;
  logic          set_in;
  logic          a_shift_out, a_set_out, a_cfg_valid, a_cfg_err, a_busy;
  logic [W-1:0]  a_cfg_out;
  logic          b_shift_out, b_set_out, b_cfg_valid, b_cfg_err, b_busy;
  logic [W-1:0]  b_cfg_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  cfg_tile_loader #(.CFG_WIDTH(W)) u_a (
    .clk(clk), .rst_n(rst_n), .shift_in(shift_in), .shift_en(shift_en), .set_in(set_in),
    .shift_out(a_shift_out), .set_out(a_set_out), .cfg_out(a_cfg_out),
    .cfg_valid(a_cfg_valid), .cfg_err(a_cfg_err), .busy(a_busy)
  );

  cfg_tile_loader #(.CFG_WIDTH(W)) u_b (
    .clk(clk), .rst_n(rst_n), .shift_in(a_shift_out), .shift_en(shift_en), .set_in(a_set_out),
    .shift_out(b_shift_out), .set_out(b_set_out), .cfg_out(b_cfg_out),
    .cfg_valid(b_cfg_valid), .cfg_err(b_cfg_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Byte-wise CRC-8 (poly 0x07, init 0) over the 16-bit data field.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int by = 1; by >= 0; by--) begin
      c = c ^ d[by*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Transaction-level model: frame contents, remaining busy cycles, and the
  // verdict applied when the busy countdown expires.
  logic [23:0] m_fr [2];
  logic [15:0] m_cfg[2];
  logic        m_val[2], m_err[2], m_ovr[2], m_so[2];
  int          m_bc [2];
  logic        mb_si, mb_st;

  task automatic model_tile(input int t, input logic si, input logic se, input logic st);
    m_so[t] = st;
    if (m_bc[t] > 0) begin
      if (se && m_bc[t] > 1) m_ovr[t] = 1'b1;
      m_bc[t] = m_bc[t] - 1;
      if (m_bc[t] == 0) begin
        if (crc8(m_fr[t][23:8]) == m_fr[t][7:0] && !m_ovr[t]) begin
          m_cfg[t] = m_fr[t][23:8];
          m_val[t] = 1'b1;
          m_err[t] = 1'b0;
        end else begin
          m_err[t] = 1'b1;
        end
        m_ovr[t] = 1'b0;
      end
    end else begin
      if (se) m_fr[t] = {m_fr[t][22:0], si};
      if (st) m_bc[t] = W + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int t = 0; t < 2; t++) begin
          m_fr[t] = '0; m_cfg[t] = '0; m_val[t] = 0; m_err[t] = 0;
          m_ovr[t] = 0; m_so[t] = 0; m_bc[t] = 0;
        end
      end else begin
        mb_si = m_fr[0][23];
        mb_st = m_so[0];
        model_tile(0, shift_in, shift_en, set_in);
        model_tile(1, mb_si, shift_en, mb_st);
      end
    end
  end

  initial begin
    wait (chk_on);
    forever begin
      @(negedge clk);
      chk("a_shift_out", a_shift_out, m_fr[0][23]);
      chk("a_set_out",   a_set_out,   m_so[0]);
      chk("a_cfg_out",   a_cfg_out,   m_cfg[0]);
      chk("a_cfg_valid", a_cfg_valid, m_val[0]);
      chk("a_cfg_err",   a_cfg_err,   m_err[0]);
      chk("a_busy",      a_busy,      m_bc[0] > 0);
      chk("b_shift_out", b_shift_out, m_fr[1][23]);
      chk("b_set_out",   b_set_out,   m_so[1]);
      chk("b_cfg_out",   b_cfg_out,   m_cfg[1]);
      chk("b_cfg_valid", b_cfg_valid, m_val[1]);
      chk("b_cfg_err",   b_cfg_err,   m_err[1]);
      chk("b_busy",      b_busy,      m_bc[1] > 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic shift_frame(input logic [23:0] f);
    for (int i = 23; i >= 0; i--) begin
      shift_in = f[i];
      shift_en = 1'b1;
      @(posedge clk); #1;
    end
    shift_en = 1'b0;
    shift_in = 1'b0;
  endtask

  task automatic pulse_set();
    set_in = 1'b1;
    @(posedge clk); #1;
    set_in = 1'b0;
  endtask

  task automatic wait_a_idle(output int n);
    bit done;
    n = 0;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (!a_busy) done = 1;
      else n++;
    end
    if (!done) chk("wait_a_idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  int nb;
  int ta, tbb;

  initial begin
    rst_n = 1'b0; shift_in = 1'b0; shift_en = 1'b0; set_in = 1'b0;
    idle(3);
    chk("rst_busy", a_busy, 0);
    chk("rst_cfg_valid", a_cfg_valid, 0);
    chk("rst_cfg_out", a_cfg_out, 0);
    chk("rst_cfg_err", a_cfg_err, 0);
    chk("rst_set_out", a_set_out, 0);
    chk("rst_shift_out", a_shift_out, 0);
    chk("model_crc_0001", crc8(16'h0001), 8'h07);
    chk("model_crc_0100", crc8(16'h0100), 8'h15);
    chk("model_crc_1234", crc8(16'h1234), 8'hF1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1;
    @(posedge clk); #1;

    // Bad CRC from reset: rejected, nothing committed.
    shift_frame({16'h0001, 8'h08});
    pulse_set();
    wait_a_idle(nb);
    idle(3);
    chk("s2_err", a_cfg_err, 1);
    chk("s2_valid", a_cfg_valid, 0);
    chk("s2_cfg", a_cfg_out, 16'h0000);

    // Good frame.
    shift_frame({16'h0001, 8'h07});
    pulse_set();
    wait_a_idle(nb);
    chk("s1_busy_cycles", nb, 17);
    idle(3);
    chk("s1_cfg", a_cfg_out, 16'h0001);
    chk("s1_valid", a_cfg_valid, 1);
    chk("s1_err", a_cfg_err, 0);

    // Bad frame keeps the last good config, then an all-zero frame commits.
    shift_frame({16'hFFFF, 8'h00});
    pulse_set();
    wait_a_idle(nb);
    idle(3);
    chk("s3_err", a_cfg_err, 1);
    chk("s3_cfg_held", a_cfg_out, 16'h0001);
    chk("s3_valid_held", a_cfg_valid, 1);
    shift_frame({16'h0000, 8'h00});
    pulse_set();
    wait_a_idle(nb);
    idle(3);
    chk("s3b_cfg", a_cfg_out, 16'h0000);
    chk("s3b_err", a_cfg_err, 0);

    // Shift during CHECK is dropped and fails the check; re-set passes.
    shift_frame({16'h0100, 8'h15});
    pulse_set();
    idle(2);
    shift_in = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1;
    shift_in = 1'b0; shift_en = 1'b0;
    chk("s4_shift_out_held", a_shift_out, 0);
    wait_a_idle(nb);
    idle(3);
    chk("s4_err", a_cfg_err, 1);
    chk("s4_cfg_held", a_cfg_out, 16'h0000);
    pulse_set();
    wait_a_idle(nb);
    idle(3);
    chk("s4_reset_err", a_cfg_err, 0);
    chk("s4_reset_cfg", a_cfg_out, 16'h0100);

    // Chain: B's frame first, then A's; B commits one cycle after A.
    shift_frame({16'h0100, 8'h15});
    shift_frame({16'h1234, 8'hF1});
    pulse_set();
    ta = -1; tbb = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ta < 0 && a_cfg_out == 16'h1234) ta = k;
      if (tbb < 0 && b_cfg_out == 16'h0100) tbb = k;
    end
    @(posedge clk); #1;
    chk("s5_a_latency", ta, 17);
    chk("s5_b_after_a", tbb - ta, 1);
    chk("s5_b_valid", b_cfg_valid, 1);
    chk("s5_b_err", b_cfg_err, 0);
    chk("s5_a_err", a_cfg_err, 0);

    // Reset in the fifth CHECK cycle aborts everything at once.
    pulse_set();
    idle(4);
    chk("s6_busy_before", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_busy", a_busy, 0);
    chk("s6_valid", a_cfg_valid, 0);
    chk("s6_cfg", a_cfg_out, 16'h0000);
    chk("s6_err", a_cfg_err, 0);
    chk("s6_b_valid", b_cfg_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("s6_idle_after", a_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
